adder_ring_counter: RTL and testbench

Measurement stage directly downstream of the instrumented ripple adder. It enables the adder's ring loop, samples the ring output (chain_out) through a synchronizer and counts its rising edges over a programmable window of wb_clk_i cycles. The result is a count proportional to ring frequency, and so to adder propagation delay, presented to the LA/wishbone readback logic.

---
 rtl/adder_ring_counter.sv | 148 ++++++++++++++
 tb/tb_adder_ring_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_ring_counter.sv
// adder_ring_counter
//   Measures the instrumented ripple adder's ring frequency: enables the
//   ring loop, lets it settle, then counts synchronized rising edges of
//   chain_out over a programmable window of wb_clk_i cycles.
//
// Ports:
//   wb_clk_i   sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      measurement request, sampled only while idle
//   window     count window length in cycles, captured on accepted start
//   chain_out  asynchronous ring output from the adder
//   ring_en    enables the adder ring loop (registered)
//   busy       high while settling or counting
//   done       one-cycle pulse when count/overflow are valid
//   count      rising edges seen in the last window (saturating)
//   overflow   count saturated during the last window
module adder_ring_counter #(
   parameter int unsigned COUNT_W     = 32,
   parameter int unsigned WINDOW_W    = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SETTLE      = 4
) (
   input  logic                wb_clk_i,
   input  logic                rst_n,
   input  logic                start,
   input  logic [WINDOW_W-1:0] window,
   input  logic                chain_out,
   output logic                ring_en,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  count,
   output logic                overflow
);

   localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARM   = 2'd1;
   localparam logic [1:0] S_COUNT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;
   logic [WINDOW_W-1:0]    win_q, win_d;
   logic [SETTLE_W-1:0]    settle_q, settle_d;
   logic [COUNT_W-1:0]     count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   ring_en_q, ring_en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   synced;
   logic                   edge_det;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], chain_out};
   assign synced   = sync_q[SYNC_STAGES-1];
   assign edge_det = synced & ~prev_q;

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      settle_d = settle_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               count_d = '0;
               ovf_d   = 1'b0;
               if (window != '0) begin
                  state_d  = S_ARM;
                  win_d    = window;
                  settle_d = SETTLE_W'(SETTLE);
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ARM: begin
            // settle_q was loaded with SETTLE on entry; leaving at 1 gives exactly SETTLE cycles here
            if (settle_q <= SETTLE_W'(1)) begin
               state_d = S_COUNT;
            end else begin
               settle_d = settle_q - SETTLE_W'(1);
            end
         end
         S_COUNT: begin
            if (edge_det) begin
               if (count_q == '1) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + COUNT_W'(1);
               end
            end
            win_d = win_q - WINDOW_W'(1);
            if (win_q == WINDOW_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from next state so they are plain flops aligned with state_q
   always_comb begin
      ring_en_d = (state_d == S_ARM) || (state_d == S_COUNT);
      busy_d    = ring_en_d;
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sync_q    <= '0;
         prev_q    <= 1'b0;
         win_q     <= '0;
         settle_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         ring_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         prev_q    <= synced;
         win_q     <= win_d;
         settle_q  <= settle_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         ring_en_q <= ring_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign ring_en  = ring_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_ring_counter.sv
module tb_adder_ring_counter;

   localparam int unsigned CW     = 4;
   localparam int unsigned WW     = 32;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned LIMIT  = 3000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [WW-1:0] window = '0;
   logic          chain_out = 1'b0;
   logic          ring_en, busy, done, overflow;
   logic [CW-1:0] count;

   adder_ring_counter #(
      .COUNT_W(CW),
      .WINDOW_W(WW),
      .SYNC_STAGES(2),
      .SETTLE(SETTLE)
   ) dut (
      .wb_clk_i(clk),
      .rst_n(rst_n),
      .start(start),
      .window(window),
      .chain_out(chain_out),
      .ring_en(ring_en),
      .busy(busy),
      .done(done),
      .count(count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   // ring stimulus: period 0 means hold gen_level
   int unsigned gen_period = 0;
   logic        gen_level  = 1'b0;
   int unsigned ph = 0;
   initial forever begin
      @(posedge clk);
      #2;
      ph++;
      if (gen_period == 0) chain_out = gen_level;
      else chain_out = ((ph % gen_period) < (gen_period / 2));
   end

   int unsigned busy_n = 0;
   int unsigned ring_n = 0;
   always @(negedge clk) begin
      if (busy) busy_n++;
      if (ring_en) ring_n++;
   end

   typedef struct {
      int unsigned cnt;
      bit          ovf;
      int unsigned lat;
   } exp_t;
   exp_t sb[$];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned t0 = 0;

   task automatic launch(input int unsigned win, input int unsigned ecnt, input bit eovf);
      exp_t e;
      e.cnt = ecnt;
      e.ovf = eovf;
      e.lat = (win == 0) ? 1 : 1 + SETTLE + win;
      sb.push_back(e);
      @(negedge clk);
      window = win;
      start  = 1'b1;
      t0     = cyc;
      busy_n = 0;
      ring_n = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      exp_t e;
      int unsigned k = 0;
      while (!done && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s_timeout: done not seen, got 0 required 1", nm);
         if (sb.size() != 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s_sb: unexpected done, got 1 required 0", nm);
      end else begin
         e = sb.pop_front();
         if ((cyc - t0) !== e.lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d required %0d", nm, cyc - t0, e.lat);
         end
         n_cmp++;
         if (count !== CW'(e.cnt)) begin
            n_bad++;
            $display("FAIL %s_count: got %0d required %0d", nm, count, e.cnt);
         end
         n_cmp++;
         if (overflow !== e.ovf) begin
            n_bad++;
            $display("FAIL %s_overflow: got %0b required %0b", nm, overflow, e.ovf);
         end
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || count !== CW'(e.cnt)) begin
            n_bad++;
            $display("FAIL %s_hold: got done=%0b count=%0d required done=0 count=%0d",
                     nm, done, count, e.cnt);
         end
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      n_cmp++;
      if ({ring_en, busy, done, overflow} !== 4'b0000 || count !== '0) begin
         n_bad++;
         $display("FAIL %s: got ring_en=%0b busy=%0b done=%0b ovf=%0b count=%0d required all 0",
                  nm, ring_en, busy, done, overflow, count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_state");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_periodic();
      gen_period = 8;
      launch(80, 10, 1'b0);
      wait_done("periodic");
      n_cmp++;
      if (busy_n !== 84 || ring_n !== 84) begin
         n_bad++;
         $display("FAIL periodic_busy: got busy=%0d ring=%0d cycles required 84", busy_n, ring_n);
      end
   endtask

   task automatic test_zero_window();
      gen_period = 8;
      launch(0, 0, 1'b0);
      wait_done("zero_window");
      n_cmp++;
      if (busy_n !== 0 || ring_n !== 0) begin
         n_bad++;
         $display("FAIL zero_window_idle: got busy=%0d ring=%0d cycles required 0", busy_n, ring_n);
      end
   endtask

   task automatic test_saturation();
      gen_period = 2;
      launch(100, 15, 1'b1);
      wait_done("saturation");
      gen_period = 8;
      launch(80, 10, 1'b0);
      n_cmp++;
      if (count !== '0 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL sat_clear: got count=%0d ovf=%0b required 0 0", count, overflow);
      end
      wait_done("after_sat");
   endtask

   task automatic test_start_ignored();
      gen_period = 8;
      launch(40, 5, 1'b0);
      repeat (20) @(negedge clk);
      window = 5;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("start_ignored");
   endtask

   task automatic test_static();
      gen_period = 0;
      gen_level  = 1'b0;
      repeat (5) @(negedge clk);
      gen_level = 1'b1;
      launch(50, 0, 1'b0);
      wait_done("static");
   endtask

   task automatic test_reset_mid();
      gen_period = 8;
      launch(1000, 0, 1'b0);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(16, 2, 1'b0);
      wait_done("after_reset");
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_zero_window();
      test_saturation();
      test_start_ignored();
      test_static();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
